// File: rtl/histogram_ctrl.sv
// Control FSM for the image-histogram stage: clears bins, sequences pixel reads, waits for the
// datapath to drain, then pulses done. Optional bin-clear phase is enabled by HIST_CLEAR_EN.

module histogram_ctrl #(
    parameter int unsigned NUM_BINS   = 256,
    parameter int unsigned BIN_ADDR_W = 8,
    parameter int unsigned NUM_PIXELS = 16384,
    parameter int unsigned PIX_ADDR_W = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_histogram,
    input  logic                  input_memory_read_finished,
    input  logic                  all_pixel_written,
    output logic                  input_mem_read_en,
    output logic [PIX_ADDR_W-1:0] input_mem_addr,
    output logic                  hist_clear_en,
    output logic [BIN_ADDR_W-1:0] hist_bin_addr,
    output logic                  busy,
    output logic                  histogram_done
);

    localparam logic [2:0] StIdle      = 3'd0;
`ifdef HIST_CLEAR_EN
    localparam logic [2:0] StClear     = 3'd1;
`endif
    localparam logic [2:0] StRead      = 3'd2;
    localparam logic [2:0] StWaitRead  = 3'd3;
    localparam logic [2:0] StWaitWrite = 3'd4;
    localparam logic [2:0] StDone      = 3'd5;

    localparam logic [PIX_ADDR_W-1:0] PixLast = PIX_ADDR_W'(NUM_PIXELS - 1);

    if (NUM_BINS != (32'd1 << BIN_ADDR_W)) begin : g_bins_chk
        $error("NUM_BINS must equal 2**BIN_ADDR_W");
    end
    if (64'(NUM_PIXELS) > (64'd1 << PIX_ADDR_W)) begin : g_pix_chk
        $error("NUM_PIXELS does not fit in PIX_ADDR_W");
    end

    logic [2:0]            state_q, state_d;
    logic                  start_prev_q;
    logic                  sticky_q, sticky_d;
    logic [PIX_ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic                  start_rise;

    assign start_rise = start_histogram & ~start_prev_q;

`ifdef HIST_CLEAR_EN
    localparam logic [BIN_ADDR_W-1:0] BinLast = BIN_ADDR_W'(NUM_BINS - 1);

    logic [BIN_ADDR_W-1:0] bin_cnt_q, bin_cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bin_cnt_q <= '0;
        end else begin
            bin_cnt_q <= bin_cnt_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            start_prev_q <= 1'b0;
            sticky_q     <= 1'b0;
            pix_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_histogram;
            sticky_q     <= sticky_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sticky_d  = sticky_q;
        pix_cnt_d = pix_cnt_q;
`ifdef HIST_CLEAR_EN
        bin_cnt_d = bin_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_rise) begin
`ifdef HIST_CLEAR_EN
                    state_d   = StClear;
                    bin_cnt_d = '0;
`else
                    state_d   = StRead;
                    pix_cnt_d = '0;
`endif
                end
            end
`ifdef HIST_CLEAR_EN
            StClear: begin
                // Early read-finished reports are remembered until the wait phase.
                sticky_d = sticky_q | input_memory_read_finished;
                if (bin_cnt_q == BinLast) begin
                    state_d   = StRead;
                    pix_cnt_d = '0;
                end else begin
                    bin_cnt_d = bin_cnt_q + BIN_ADDR_W'(1);
                end
            end
`endif
            StRead: begin
                sticky_d = sticky_q | input_memory_read_finished;
                if (pix_cnt_q == PixLast) begin
                    state_d = StWaitRead;
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_ADDR_W'(1);
                end
            end
            StWaitRead: begin
                if (input_memory_read_finished || sticky_q) begin
                    if (all_pixel_written) begin
                        state_d  = StDone;
                        sticky_d = 1'b0;
                    end else begin
                        state_d = StWaitWrite;
                    end
                end
            end
            StWaitWrite: begin
                if (all_pixel_written) begin
                    state_d  = StDone;
                    sticky_d = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only; addresses read as zero outside their phase.
    assign busy              = (state_q != StIdle);
    assign histogram_done    = (state_q == StDone);
    assign input_mem_read_en = (state_q == StRead);
    assign input_mem_addr    = {PIX_ADDR_W{input_mem_read_en}} & pix_cnt_q;

`ifdef HIST_CLEAR_EN
    assign hist_clear_en = (state_q == StClear);
    assign hist_bin_addr = {BIN_ADDR_W{hist_clear_en}} & bin_cnt_q;
`else
    assign hist_clear_en = 1'b0;
    assign hist_bin_addr = '0;
`endif

endmodule

// File: tb/tb_histogram_ctrl.sv
// Bench for histogram_ctrl: timeline model checked every cycle plus directed literal checks.
// Works with HIST_CLEAR_EN either defined or undefined.

module tb_histogram_ctrl;

    localparam int NB = 16;
    localparam int BW = 4;
    localparam int NP = 40;
    localparam int PW = 6;
`ifdef HIST_CLEAR_EN
    localparam int CLR = NB;
`else
    localparam int CLR = 0;
`endif
    localparam int L = CLR + NP;

    logic          clock;
    logic          reset;
    logic          start;
    logic          fin;
    logic          wr;
    logic          read_en;
    logic [PW-1:0] addr;
    logic          clear_en;
    logic [BW-1:0] bin;
    logic          busy;
    logic          done;

    histogram_ctrl #(
        .NUM_BINS   (NB),
        .BIN_ADDR_W (BW),
        .NUM_PIXELS (NP),
        .PIX_ADDR_W (PW)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .start_histogram            (start),
        .input_memory_read_finished (fin),
        .all_pixel_written          (wr),
        .input_mem_read_en          (read_en),
        .input_mem_addr             (addr),
        .hist_clear_en              (clear_en),
        .hist_bin_addr              (bin),
        .busy                       (busy),
        .histogram_done             (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is a timeline of cycles t=1.. after the accepted start edge; cycles 1..CLR
    // clear, CLR+1..L read, then wait until the finish/write conditions are observed.
    bit m_active, m_done, m_fin, m_wwait, m_prev_s;
    bit p_rst, p_s, p_f, p_w;
    int m_t;

    initial begin
        m_active = 0; m_done = 0; m_fin = 0; m_wwait = 0; m_prev_s = 0; m_t = 0;
        p_rst = 0; p_s = 0; p_f = 0; p_w = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_active = 0;
                m_done   = 0;
                m_prev_s = 0;
            end else if (p_rst) begin
                bit rise;
                rise     = p_s && !m_prev_s;
                m_prev_s = p_s;
                if (m_done) begin
                    m_done   = 0;
                    m_active = 0;
                end else if (!m_active) begin
                    if (rise) begin
                        m_active = 1; m_t = 1; m_fin = 0; m_wwait = 0;
                    end
                end else if (m_t <= L) begin
                    m_fin = m_fin | p_f;
                    m_t++;
                end else if (!m_wwait) begin
                    if (p_f || m_fin) begin
                        if (p_w) begin
                            m_done = 1; m_fin = 0;
                        end else begin
                            m_wwait = 1;
                        end
                    end
                end else if (p_w) begin
                    m_done = 1; m_fin = 0;
                end
            end
            begin
                bit e_clr, e_rd;
                e_clr = m_active && !m_done && m_t >= 1 && m_t <= CLR;
                e_rd  = m_active && !m_done && m_t > CLR && m_t <= L;
                chk("m_busy", busy, m_active);
                chk("m_done", done, m_done);
                chk("m_clear_en", clear_en, e_clr);
                chk("m_bin", bin, e_clr ? m_t - 1 : 0);
                chk("m_read_en", read_en, e_rd);
                chk("m_addr", addr, e_rd ? m_t - CLR - 1 : 0);
            end
            p_rst = reset; p_s = start; p_f = fin; p_w = wr;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        int n;
        bit hit;
        reset = 1'b0; start = 1'b0; fin = 1'b0; wr = 1'b0;
        tick(1);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read_en", read_en, 0);
        chk("rst_clear_en", clear_en, 0);
        tick(1);
        reset = 1'b1;
        tick(2);
        start = 1'b1;

        // Run 1: full sequence, idle wait, then finish then write three cycles later.
        tick(1);
        #1;
        chk("first_busy", busy, 1);
`ifdef HIST_CLEAR_EN
        chk("first_clear_en", clear_en, 1);
        chk("first_bin", bin, 0);
        chk("first_read_en", read_en, 0);
`else
        chk("first_read_en", read_en, 1);
        chk("first_addr", addr, 0);
        chk("first_clear_en", clear_en, 0);
`endif
        tick(L - 1);
        #1;
        chk("last_read_en", read_en, 1);
        chk("last_addr", addr, NP - 1);
        tick(5);
        #1;
        chk("waitrd_busy", busy, 1);
        chk("waitrd_read_en", read_en, 0);
        chk("waitrd_done", done, 0);
        fin = 1'b1;
        tick(1);
        fin = 1'b0;
        tick(2);
        wr = 1'b1;
        #1;
        chk("pre_done", done, 0);
        tick(1);
        wr = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        tick(1);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);

        // Run 2: finish reported early, write arrives later in the wait phase.
        start = 1'b0;
        tick(2);
        start = 1'b1;
        tick(4);
        fin = 1'b1;
        tick(1);
        fin = 1'b0;
        tick(L - 2);
        #1;
        chk("sticky_busy", busy, 1);
        chk("sticky_no_done", done, 0);
        wr = 1'b1;
        tick(1);
        wr = 1'b0;
        #1;
        chk("sticky_done", done, 1);
        tick(1);

        // Run 3: both done inputs high throughout gives minimum latency.
        start = 1'b0;
        fin = 1'b1;
        wr = 1'b1;
        tick(1);
        start = 1'b1;
        n = 0;
        hit = 0;
        while (!hit && n < L + 10) begin
            tick(1);
            n++;
            if (done) hit = 1;
        end
        chk("min_latency", n, L + 2);
        fin = 1'b0;
        wr = 1'b0;
        tick(1);

        // Run 4: reset during read aborts; restart needs a fresh start edge.
        start = 1'b0;
        tick(1);
        start = 1'b1;
        n = 0;
        hit = 0;
        while (!hit && n < L + 5) begin
            tick(1);
            n++;
            if (read_en && addr == 20) hit = 1;
        end
        chk("reach_addr20", hit, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_read_en", read_en, 0);
        chk("abort_addr", addr, 0);
        chk("abort_clear_en", clear_en, 0);
        chk("abort_done", done, 0);
        start = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        #1;
        chk("no_restart", busy, 0);
        start = 1'b1;
        tick(1);
        #1;
        chk("restart_busy", busy, 1);
        fin = 1'b1;
        wr = 1'b1;
        n = 0;
        hit = 0;
        while (!hit && n < L + 10) begin
            tick(1);
            n++;
            if (done) hit = 1;
        end
        chk("restart_done", hit, 1);
        fin = 1'b0;
        wr = 1'b0;
        start = 1'b0;
        tick(3);
        #1;
        chk("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
